// File: rtl/disp_scan_8x7seg.sv
`default_nettype none
// ============================================================================
// Module  : disp_scan_8x7seg
// Brief   : Time-multiplexed N-digit 7-segment scanner with anode dead time
//           and frame-synchronous double-buffered display data.
// Revision: 1.0
// ============================================================================
module disp_scan_8x7seg #(
    parameter int N_DIG       = 8,
    parameter int DEAD_CYC    = 4,
    parameter int AN_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 DISP_CE,
    input  logic                 LOAD,
    input  logic [4*N_DIG-1:0]   DATA,
    input  logic [N_DIG-1:0]     DP,
    input  logic [N_DIG-1:0]     DIG_EN,
    output logic [N_DIG-1:0]     AN,
    output logic [6:0]           SEG,
    output logic                 SEG_DP,
    output logic                 FRAME_DONE,
    output logic                 PENDING
);

    localparam int                 c_idx_w    = $clog2(N_DIG);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_DIG - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [7:0]         c_dead     = 8'(DEAD_CYC);
    localparam logic               c_an_off   = (AN_ACT_LOW != 0);
    localparam logic               c_seg_off  = (SEG_ACT_LOW != 0);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_idx_w-1:0]   r_idx, w_idx_nxt;
    logic [7:0]           r_cnt, w_cnt_nxt;
    logic [4*N_DIG-1:0]   r_sh_data, r_act_data, w_act_data_nxt;
    logic [N_DIG-1:0]     r_sh_dp, r_act_dp, w_act_dp_nxt;
    logic [N_DIG-1:0]     r_sh_en, r_act_en, w_act_en_nxt;
    logic                 r_pending, w_pending_nxt;
    logic                 r_frame_done;
    logic [N_DIG-1:0]     r_an, w_an_nxt;
    logic [6:0]           r_seg, w_seg_nxt;
    logic                 r_seg_dp, w_seg_dp_nxt;
    logic                 w_wrap;
    logic                 w_xfer;
    logic [3:0]           w_nib;

    // Active-high gfedcba segment pattern for one hex nibble.
    function automatic logic [6:0] hexdec(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_wrap         = DISP_CE && (r_idx == c_idx_last);
        w_xfer         = w_wrap && r_pending;
        w_act_data_nxt = w_xfer ? r_sh_data : r_act_data;
        w_act_dp_nxt   = w_xfer ? r_sh_dp   : r_act_dp;
        w_act_en_nxt   = w_xfer ? r_sh_en   : r_act_en;
        w_pending_nxt  = LOAD ? 1'b1 : (w_wrap ? 1'b0 : r_pending);

        if (DISP_CE) begin
            w_idx_nxt   = w_wrap ? '0 : r_idx + c_idx_one;
            w_cnt_nxt   = c_dead;
            w_state_nxt = (c_dead == 8'd0) ? ST_SHOW : ST_BLANK;
        end else if (r_state == ST_BLANK) begin
            // Leave BLANK on the cycle the counter would reach zero so the
            // anode lights exactly DEAD_CYC cycles after the blanking edge.
            if (r_cnt <= 8'd1) begin
                w_state_nxt = ST_SHOW;
            end
            w_cnt_nxt = (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;
        end

        // Outputs are derived from next-state values, so they are registered
        // without adding a cycle of latency.
        w_nib        = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_an_nxt     = {N_DIG{c_an_off}};
        w_seg_nxt    = {7{c_seg_off}};
        w_seg_dp_nxt = c_seg_off;
        if (w_state_nxt == ST_SHOW) begin
            if (w_act_en_nxt[w_idx_nxt]) begin
                w_an_nxt[w_idx_nxt] = ~c_an_off;
            end
            w_seg_nxt    = hexdec(w_nib) ^ {7{c_seg_off}};
            w_seg_dp_nxt = w_act_dp_nxt[w_idx_nxt] ^ c_seg_off;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_BLANK;
            r_idx        <= '0;
            r_cnt        <= c_dead;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_en      <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_an         <= {N_DIG{c_an_off}};
            r_seg        <= {7{c_seg_off}};
            r_seg_dp     <= c_seg_off;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            if (LOAD) begin
                r_sh_data <= DATA;
                r_sh_dp   <= DP;
                r_sh_en   <= DIG_EN;
            end
            r_act_data   <= w_act_data_nxt;
            r_act_dp     <= w_act_dp_nxt;
            r_act_en     <= w_act_en_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_done <= w_wrap;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_seg_dp     <= w_seg_dp_nxt;
        end
    end

    assign AN         = r_an;
    assign SEG        = r_seg;
    assign SEG_DP     = r_seg_dp;
    assign FRAME_DONE = r_frame_done;
    assign PENDING    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_8x7seg.sv
`default_nettype none
// ============================================================================
// Module  : tb_disp_scan_8x7seg
// Brief   : Directed bench for disp_scan_8x7seg (dead time 4 and dead time 0).
// Revision: 1.0
// ============================================================================
module tb_disp_scan_8x7seg;

    localparam int GAP = 12;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        DISP_CE;
    logic        LOAD;
    logic [31:0] DATA;
    logic [7:0]  DP;
    logic [7:0]  DIG_EN;

    logic [7:0]  AN,     an_b;
    logic [6:0]  SEG,    seg_b;
    logic        SEG_DP, seg_dp_b;
    logic        FRAME_DONE, fd_b;
    logic        PENDING,    pend_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] e_data;
    logic [7:0]  e_dp;
    logic [7:0]  e_en;
    logic        e_pend;

    disp_scan_8x7seg #(.N_DIG(8), .DEAD_CYC(4), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .DISP_CE(DISP_CE), .LOAD(LOAD), .DATA(DATA),
        .DP(DP), .DIG_EN(DIG_EN), .AN(AN), .SEG(SEG), .SEG_DP(SEG_DP),
        .FRAME_DONE(FRAME_DONE), .PENDING(PENDING)
    );

    disp_scan_8x7seg #(.N_DIG(8), .DEAD_CYC(0), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)) u_dut_nodead (
        .CLK(CLK), .RST_N(RST_N), .DISP_CE(DISP_CE), .LOAD(LOAD), .DATA(DATA),
        .DP(DP), .DIG_EN(DIG_EN), .AN(an_b), .SEG(seg_b), .SEG_DP(seg_dp_b),
        .FRAME_DONE(fd_b), .PENDING(pend_b)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] ld_data, input logic [7:0] ld_dp, input logic [7:0] ld_en);
        DATA   = ld_data;
        DP     = ld_dp;
        DIG_EN = ld_en;
        LOAD   = 1'b1;
        tick();
        LOAD   = 1'b0;
        chk("pending_after_load", {31'd0, PENDING}, 32'd1);
    endtask

    // One DISP_CE moving to digit idx; expectations come from e_* (hand-set).
    task automatic step(input int idx, input logic wrap);
        logic [7:0] an_x;
        logic [6:0] seg_x;
        logic       dp_x;
        logic [3:0] nib;
        nib   = e_data[idx*4 +: 4];
        an_x  = e_en[idx] ? ~(8'h01 << idx) : 8'hFF;
        seg_x = ~hex7(nib);
        dp_x  = ~e_dp[idx];
        DISP_CE = 1'b1;
        tick();
        DISP_CE = 1'b0;
        LOAD    = 1'b0;
        chk("frame_done_at_ce", {31'd0, FRAME_DONE}, {31'd0, wrap});
        chk("an_blank_ce",      {24'd0, AN},   32'h0000_00FF);
        chk("seg_blank_ce",     {25'd0, SEG},  32'h0000_007F);
        chk("an_nodead",        {24'd0, an_b}, {24'd0, an_x});
        chk("seg_nodead",       {25'd0, seg_b}, {25'd0, seg_x});
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("an_dead_time", {24'd0, AN}, 32'h0000_00FF);
        end
        tick();
        chk("an_show",          {24'd0, AN},  {24'd0, an_x});
        chk("seg_show",         {25'd0, SEG}, {25'd0, seg_x});
        chk("seg_dp_show",      {31'd0, SEG_DP}, {31'd0, dp_x});
        chk("frame_done_idle",  {31'd0, FRAME_DONE}, 32'd0);
        chk("pending_show",     {31'd0, PENDING}, {31'd0, e_pend});
        repeat (GAP) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; DISP_CE = 1'b0; LOAD = 1'b0;
        DATA = '0; DP = '0; DIG_EN = '0;
        e_data = '0; e_dp = '0; e_en = '0; e_pend = 1'b0;
        repeat (3) tick();
        chk("rst_an",     {24'd0, AN},  32'h0000_00FF);
        chk("rst_seg",    {25'd0, SEG}, 32'h0000_007F);
        chk("rst_seg_dp", {31'd0, SEG_DP}, 32'd1);
        chk("rst_fd",     {31'd0, FRAME_DONE}, 32'd0);
        chk("rst_pend",   {31'd0, PENDING}, 32'd0);
        chk("rst_an_nodead", {24'd0, an_b}, 32'h0000_00FF);
        RST_N = 1'b1;
        repeat (6) tick();

        // Frame 0: active buffer still empty, everything dark.
        load(32'h8765_4321, 8'h00, 8'hFF); e_pend = 1'b1;
        for (int i = 1; i < 8; i++) step(i, 1'b0);

        // Wrap 1: first data appears; LOAD mid-frame at digit 3.
        e_data = 32'h8765_4321; e_dp = 8'h00; e_en = 8'hFF; e_pend = 1'b0;
        step(0, 1'b1);
        for (int i = 1; i < 4; i++) step(i, 1'b0);
        load(32'hFEDC_BA90, 8'h00, 8'hFF); e_pend = 1'b1;
        for (int i = 4; i < 8; i++) step(i, 1'b0);

        // Wrap 2: new data from digit 0; another LOAD mid-frame.
        e_data = 32'hFEDC_BA90; e_pend = 1'b0;
        step(0, 1'b1);
        for (int i = 1; i < 3; i++) step(i, 1'b0);
        load(32'h7654_3210, 8'h01, 8'hFF); e_pend = 1'b1;
        for (int i = 3; i < 8; i++) step(i, 1'b0);

        // Wrap 3 with coincident LOAD: older shadow shown, pending stays set.
        DATA = 32'hFEDC_BA98; DP = 8'h01; DIG_EN = 8'h0F; LOAD = 1'b1;
        e_data = 32'h7654_3210; e_dp = 8'h01; e_en = 8'hFF; e_pend = 1'b1;
        step(0, 1'b1);
        for (int i = 1; i < 8; i++) step(i, 1'b0);

        // Wrap 4: partial enable mask, decimal point on digit 0.
        e_data = 32'hFEDC_BA98; e_dp = 8'h01; e_en = 8'h0F; e_pend = 1'b0;
        step(0, 1'b1);
        for (int i = 1; i < 5; i++) step(i, 1'b0);
        load(32'h1357_9BDF, 8'h00, 8'hFF); e_pend = 1'b1;
        for (int i = 5; i < 8; i++) step(i, 1'b0);

        // Wrap 5, then reset while digit 5 is lit.
        e_data = 32'h1357_9BDF; e_dp = 8'h00; e_en = 8'hFF; e_pend = 1'b0;
        step(0, 1'b1);
        for (int i = 1; i < 6; i++) step(i, 1'b0);
        RST_N = 1'b0;
        #2;
        chk("async_rst_an",     {24'd0, AN},  32'h0000_00FF);
        chk("async_rst_seg",    {25'd0, SEG}, 32'h0000_007F);
        chk("async_rst_seg_dp", {31'd0, SEG_DP}, 32'd1);
        chk("async_rst_an_nodead", {24'd0, an_b}, 32'h0000_00FF);
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
        chk("post_rst_fd",   {31'd0, FRAME_DONE}, 32'd0);
        chk("post_rst_pend", {31'd0, PENDING}, 32'd0);

        // Buffers cleared; first CE goes to digit 1, so the wrap is the 8th CE.
        e_data = '0; e_dp = '0; e_en = '0; e_pend = 1'b0;
        load(32'hA5A5_A5A5, 8'h80, 8'hFF); e_pend = 1'b1;
        for (int i = 1; i < 8; i++) step(i, 1'b0);
        e_data = 32'hA5A5_A5A5; e_dp = 8'h80; e_en = 8'hFF; e_pend = 1'b0;
        step(0, 1'b1);
        step(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
